dispatch_arbiter: RTL and testbench

- Collects decoded instructions from several format decoders and serialises them into one in-order dispatch stream. The XO, X, D and other format decoders are the requesters.
- Each decoder lane has a one-entry pending slot. A round-robin arbiter moves one pending entry per cycle into a dispatch FIFO, and the FIFO head is offered to the issue stage with a valid/ready handshake.
- The block drives the shared stall back to fetch/decode.

---
 rtl/dispatch_arbiter_pkg.sv | 41 ++++
 rtl/dispatch_arbiter_rr.sv | 34 +++
 rtl/dispatch_arbiter.sv | 108 ++++++++++
 tb/tb_dispatch_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dispatch_arbiter_pkg.sv
// rtl/dispatch_arbiter_pkg.sv - shared unit codes, payload layout and entry type for the dispatch arbiter
package dispatch_arbiter_pkg;

  localparam int FU_W  = 3;
  localparam int XOP_W = 10;
  localparam int REG_W = 5;

  typedef enum logic [FU_W-1:0] {
    FU_FX     = 3'd0,
    FU_FP     = 3'd1,
    FU_LDST   = 3'd2,
    FU_BRANCH = 3'd3,
    FU_TRAP   = 3'd4
  } fu_e;

  function automatic int payload_width(int fuw, int xopw, int regw);
    return fuw + xopw + 3 * regw + 2;
  endfunction

  localparam int PW = payload_width(FU_W, XOP_W, REG_W);

  // Field LSB offsets inside the packed payload {fu, xop, r1, r2, r3, bit1, bit2}
  localparam int BIT2_LSB = 0;
  localparam int BIT1_LSB = 1;
  localparam int R3_LSB   = 2;
  localparam int R2_LSB   = R3_LSB + REG_W;
  localparam int R1_LSB   = R2_LSB + REG_W;
  localparam int XOP_LSB  = R1_LSB + REG_W;
  localparam int FU_LSB   = XOP_LSB + XOP_W;

  typedef struct packed {
    fu_e              fu;
    logic [XOP_W-1:0] xop;
    logic [REG_W-1:0] r1;
    logic [REG_W-1:0] r2;
    logic [REG_W-1:0] r3;
    logic             bit1;
    logic             bit2;
  } dispatch_entry_t;

endpackage

// File: rtl/dispatch_arbiter_rr.sv
// rtl/dispatch_arbiter_rr.sv - round-robin grant search starting at a rotating pointer
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_idx_o,
  output logic                       grant_any_o
);

  localparam int SW = $clog2(NUM_REQ);

  logic [SW-1:0] idx;
  logic          found;

  // NUM_REQ is a power of two, so the pointer sum wraps modulo NUM_REQ for free
  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr_i + SW'(i);
      if (!found && req_i[idx]) begin
        found       = 1'b1;
        grant_idx_o = idx;
      end
    end
    if (found) grant_o[grant_idx_o] = 1'b1;
    grant_any_o = found;
  end

endmodule

// File: rtl/dispatch_arbiter.sv
// rtl/dispatch_arbiter.sv - per-lane pending slots, round-robin selection and show-ahead dispatch FIFO
module dispatch_arbiter
  import dispatch_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int QDEPTH  = 4,
  parameter int XOPW    = XOP_W,
  parameter int REGW    = REG_W,
  parameter int FUW     = FU_W,
  parameter int PW      = payload_width(FUW, XOPW, REGW)
) (
  input  logic                       clock_i,
  input  logic                       resetn_i,
  input  logic [NUM_REQ-1:0]         req_valid_i,
  input  logic [NUM_REQ*PW-1:0]      req_payload_i,
  output logic                       stall_o,
  output logic                       disp_valid_o,
  input  logic                       disp_ready_i,
  output logic [PW-1:0]              disp_payload_o,
  output logic [$clog2(NUM_REQ)-1:0] disp_src_o,
  output logic                       overflow_o
);

  localparam int SW = $clog2(NUM_REQ);
  localparam int QW = $clog2(QDEPTH);

  if (FUW < 3) begin : g_fuw_check
    $error("FUW must be at least 3 to encode the TRAP unit");
  end

  logic [NUM_REQ-1:0] slot_valid_q, slot_valid_d;
  logic [PW-1:0]      slot_payload_q [NUM_REQ];
  logic [PW-1:0]      fifo_payload_q [QDEPTH];
  logic [SW-1:0]      fifo_src_q     [QDEPTH];
  logic [QW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [QW:0]        count_q, count_d;
  logic [SW-1:0]      rr_ptr_q, rr_ptr_d;
  logic               overflow_q, overflow_d;

  logic [NUM_REQ-1:0] arb_req, grant, load;
  logic [SW-1:0]      grant_idx;
  logic               grant_any, push_ok, pop;

  assign disp_valid_o = (count_q != '0);
  assign pop          = disp_valid_o && disp_ready_i;
  assign push_ok      = (count_q < (QW+1)'(QDEPTH)) || pop;
  assign arb_req      = slot_valid_q & {NUM_REQ{push_ok}};

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i       (arb_req),
    .ptr_i       (rr_ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .grant_any_o (grant_any)
  );

  // A slot granted this cycle frees in time to accept a new request at the same edge
  assign load = req_valid_i & (~slot_valid_q | grant);

  always_comb begin
    slot_valid_d = (slot_valid_q & ~grant) | load;
    overflow_d   = overflow_q | (|(req_valid_i & ~load));
    wr_ptr_d     = grant_any ? wr_ptr_q + QW'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + QW'(1) : rd_ptr_q;
    rr_ptr_d     = grant_any ? grant_idx + SW'(1) : rr_ptr_q;
    count_d      = count_q;
    case ({grant_any, pop})
      2'b10:   count_d = count_q + (QW+1)'(1);
      2'b01:   count_d = count_q - (QW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      slot_valid_q <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      rr_ptr_q     <= '0;
      overflow_q   <= 1'b0;
    end else begin
      slot_valid_q <= slot_valid_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      rr_ptr_q     <= rr_ptr_d;
      overflow_q   <= overflow_d;
    end
  end

  // Data storage is qualified by the valid state above, so it needs no reset
  always_ff @(posedge clock_i) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (load[k]) slot_payload_q[k] <= req_payload_i[k*PW +: PW];
    end
    if (grant_any) begin
      fifo_payload_q[wr_ptr_q] <= slot_payload_q[grant_idx];
      fifo_src_q[wr_ptr_q]     <= grant_idx;
    end
  end

  assign disp_payload_o = disp_valid_o ? fifo_payload_q[rd_ptr_q] : '0;
  assign disp_src_o     = disp_valid_o ? fifo_src_q[rd_ptr_q] : '0;
  assign stall_o        = (|slot_valid_q) || (count_q >= (QW+1)'(QDEPTH - 1));
  assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_dispatch_arbiter.sv
// tb/tb_dispatch_arbiter.sv - directed vector and sequence bench for dispatch_arbiter
module tb_dispatch_arbiter;
  import dispatch_arbiter_pkg::*;

  localparam int N = 4;
  localparam int Q = 4;

  logic            clock_i = 1'b0;
  logic            resetn_i;
  logic [N-1:0]    req_valid_i;
  logic [N*PW-1:0] req_payload_i;
  logic            stall_o, disp_valid_o, disp_ready_i, overflow_o;
  logic [PW-1:0]   disp_payload_o;
  logic [1:0]      disp_src_o;

  int total = 0;
  int bad   = 0;

  always #5 clock_i = ~clock_i;

  dispatch_arbiter #(.NUM_REQ(N), .QDEPTH(Q), .XOPW(XOP_W), .REGW(REG_W), .FUW(3)) dut (
    .clock_i        (clock_i),
    .resetn_i       (resetn_i),
    .req_valid_i    (req_valid_i),
    .req_payload_i  (req_payload_i),
    .stall_o        (stall_o),
    .disp_valid_o   (disp_valid_o),
    .disp_ready_i   (disp_ready_i),
    .disp_payload_o (disp_payload_o),
    .disp_src_o     (disp_src_o),
    .overflow_o     (overflow_o)
  );

  typedef struct {
    logic [3:0] v;
    logic       rdy;
    int         base;
    logic       ev;
    int         esrc;
    int         exop;
    logic       estall;
  } vec_t;

  vec_t tbl[$];
  int   exp_src[$];
  int   exp_xop[$];

  function automatic logic [PW-1:0] mk(int lane, int xop);
    dispatch_entry_t e;
    e.fu   = FU_FX;
    e.xop  = XOP_W'(xop);
    e.r1   = REG_W'(lane + 1);
    e.r2   = REG_W'(lane + 2);
    e.r3   = REG_W'(lane + 3);
    e.bit1 = lane[0];
    e.bit2 = lane[1];
    return e;
  endfunction

  function automatic vec_t mkv(logic [3:0] v, logic rdy, int base, logic ev, int esrc, int exop, logic estall);
    vec_t t;
    t.v = v; t.rdy = rdy; t.base = base; t.ev = ev;
    t.esrc = esrc; t.exop = exop; t.estall = estall;
    return t;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(logic [3:0] v, int base);
    req_valid_i = v;
    for (int k = 0; k < N; k++) req_payload_i[k*PW +: PW] = mk(k, base + k);
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drain(string name);
    drive(4'b0000, 0);
    disp_ready_i = 1'b1;
    while (exp_src.size() > 0) begin
      int n = 0;
      int s = exp_src.pop_front();
      int x = exp_xop.pop_front();
      while (!disp_valid_o && n < 20) begin
        step();
        n++;
      end
      if (!disp_valid_o) begin
        chk({name, "_timeout"}, 64'(disp_valid_o), 64'd1);
      end else begin
        chk({name, "_src"}, 64'(disp_src_o), 64'(s));
        chk({name, "_payload"}, 64'(disp_payload_o), 64'(mk(s, x)));
        step();
      end
    end
    chk({name, "_empty"}, 64'(disp_valid_o), 64'd0);
    disp_ready_i = 1'b0;
  endtask

  initial begin
    resetn_i      = 1'b0;
    disp_ready_i  = 1'b0;
    req_valid_i   = '0;
    req_payload_i = '0;
    step();
    step();
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_valid", 64'(disp_valid_o), 64'd0);
    chk("rst_payload", 64'(disp_payload_o), 64'd0);
    chk("rst_src", 64'(disp_src_o), 64'd0);
    chk("rst_overflow", 64'(overflow_o), 64'd0);
    #3 resetn_i = 1'b1;
    step();

    // burst 1 (rr=0): 0,1,2,3
    tbl.push_back(mkv(4'b1111, 1, 100, 0, 0, 0,   1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 0, 100, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 1, 101, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 2, 102, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 3, 103, 0));
    tbl.push_back(mkv(4'b0000, 1, 0,   0, 0, 0,   0));
    // burst 2 (rr back at 0): 0,1,2,3
    tbl.push_back(mkv(4'b1111, 1, 200, 0, 0, 0,   1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 0, 200, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 1, 201, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 2, 202, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 3, 203, 0));
    tbl.push_back(mkv(4'b0000, 1, 0,   0, 0, 0,   0));
    // single request lane 2, xop 266, r1/r2/r3 = 3/4/5
    tbl.push_back(mkv(4'b0100, 1, 264, 0, 0, 0,   1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 2, 266, 0));
    tbl.push_back(mkv(4'b0000, 1, 0,   0, 0, 0,   0));
    // single request lane 1 leaves rr=2
    tbl.push_back(mkv(4'b0010, 1, 299, 0, 0, 0,   1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 1, 300, 0));
    tbl.push_back(mkv(4'b0000, 1, 0,   0, 0, 0,   0));
    // burst 3 (rr=2): 2,3,0,1
    tbl.push_back(mkv(4'b1111, 1, 400, 0, 0, 0,   1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 2, 402, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 3, 403, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 0, 400, 1));
    tbl.push_back(mkv(4'b0000, 1, 0,   1, 1, 401, 0));
    tbl.push_back(mkv(4'b0000, 1, 0,   0, 0, 0,   0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].v, tbl[i].base);
      disp_ready_i = tbl[i].rdy;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(disp_valid_o), 64'(tbl[i].ev));
      chk($sformatf("vec%0d_stall", i), 64'(stall_o), 64'(tbl[i].estall));
      if (tbl[i].ev) begin
        chk($sformatf("vec%0d_src", i), 64'(disp_src_o), 64'(tbl[i].esrc));
        chk($sformatf("vec%0d_payload", i), 64'(disp_payload_o), 64'(mk(tbl[i].esrc, tbl[i].exop)));
      end
    end

    // back-pressure: five single-lane requests with the issue stage stalled
    disp_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(4'(1 << (i % 4)), 800 + i - (i % 4));
      step();
      drive(4'b0000, 0);
      step();
      if (i == 1) chk("full_stall_cnt2", 64'(stall_o), 64'd0);
      if (i == 2) chk("full_stall_cnt3", 64'(stall_o), 64'd1);
    end
    step();
    chk("full_hold_valid", 64'(disp_valid_o), 64'd1);
    chk("full_hold_payload", 64'(disp_payload_o), 64'(mk(0, 800)));
    chk("full_slot_stall", 64'(stall_o), 64'd1);
    disp_ready_i = 1'b1;
    step();
    disp_ready_i = 1'b0;
    chk("pushpop_head_src", 64'(disp_src_o), 64'd1);
    chk("pushpop_head_payload", 64'(disp_payload_o), 64'(mk(1, 801)));
    chk("pushpop_stall", 64'(stall_o), 64'd1);
    exp_src = '{1, 2, 3, 0};
    exp_xop = '{801, 802, 803, 804};
    drain("pushpop_drain");

    // overflow: lane 1 requests twice while its slot waits on a full FIFO (rr=1 here)
    drive(4'b1111, 500);
    step();
    drive(4'b0000, 0);
    for (int i = 0; i < 4; i++) step();
    drive(4'b1111, 600);
    step();
    chk("ovf_before", 64'(overflow_o), 64'd0);
    drive(4'b0010, 699);
    step();
    chk("ovf_first", 64'(overflow_o), 64'd1);
    drive(4'b0010, 700);
    step();
    chk("ovf_second", 64'(overflow_o), 64'd1);
    exp_src = '{1, 2, 3, 0, 1, 2, 3, 0};
    exp_xop = '{501, 502, 503, 500, 601, 602, 603, 600};
    drain("ovf_drain");
    chk("ovf_sticky", 64'(overflow_o), 64'd1);

    // reset mid-operation: three queued entries plus two occupied slots
    drive(4'b0111, 900);
    step();
    drive(4'b0000, 0);
    for (int i = 0; i < 3; i++) step();
    drive(4'b0011, 910);
    step();
    chk("prerst_valid", 64'(disp_valid_o), 64'd1);
    #2 resetn_i = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_valid", 64'(disp_valid_o), 64'd0);
    chk("midrst_payload", 64'(disp_payload_o), 64'd0);
    chk("midrst_src", 64'(disp_src_o), 64'd0);
    chk("midrst_overflow", 64'(overflow_o), 64'd0);
    drive(4'b0000, 0);
    disp_ready_i = 1'b1;
    #3 resetn_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("postrst_valid%0d", i), 64'(disp_valid_o), 64'd0);
    end
    drive(4'b1000, 947);
    step();
    drive(4'b0000, 0);
    step();
    chk("postrst_new_valid", 64'(disp_valid_o), 64'd1);
    chk("postrst_new_src", 64'(disp_src_o), 64'd3);
    chk("postrst_new_payload", 64'(disp_payload_o), 64'(mk(3, 950)));
    step();
    chk("postrst_new_popped", 64'(disp_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
